// File: rtl/nx_cycle_ctrl_if.sv
// nx_cycle_ctrl_if: bundle of the controller's mesh-facing, step-control and
// token-bus signals. The master modport is the controller itself; the slave
// modport is the mesh/host side that drives enables, idles and step control.
// Optional macro NX_CYCLE_BREAK_EN adds the breakpoint signals
// break_en_i, break_cycle_i and break_o.
interface nx_cycle_ctrl_if #(
    parameter int DOMAINS       = 1,
    parameter int COLUMNS       = 3,
    parameter int COUNTER_WIDTH = 32,
    parameter int STEP_WIDTH    = 16
);
    logic                     active_i;
    logic [DOMAINS-1:0]       domain_en_i;
    logic [DOMAINS-1:0]       idle_i;
    logic [DOMAINS-1:0]       trigger_o;
    logic [COUNTER_WIDTH-1:0] counter_o;
    logic                     step_mode_i;
    logic                     step_load_i;
    logic [STEP_WIDTH-1:0]    step_count_i;
    logic [STEP_WIDTH-1:0]    steps_left_o;
    logic                     done_o;
    logic                     running_o;
    logic [COLUMNS-1:0]       token_release_i;
    logic [COLUMNS-1:0]       token_grant_o;
`ifdef NX_CYCLE_BREAK_EN
    logic                     break_en_i;
    logic [COUNTER_WIDTH-1:0] break_cycle_i;
    logic                     break_o;

    modport master (
        input  active_i, domain_en_i, idle_i, step_mode_i, step_load_i,
               step_count_i, token_release_i, break_en_i, break_cycle_i,
        output trigger_o, counter_o, steps_left_o, done_o, running_o,
               token_grant_o, break_o
    );

    modport slave (
        output active_i, domain_en_i, idle_i, step_mode_i, step_load_i,
               step_count_i, token_release_i, break_en_i, break_cycle_i,
        input  trigger_o, counter_o, steps_left_o, done_o, running_o,
               token_grant_o, break_o
    );
`else
    modport master (
        input  active_i, domain_en_i, idle_i, step_mode_i, step_load_i,
               step_count_i, token_release_i,
        output trigger_o, counter_o, steps_left_o, done_o, running_o,
               token_grant_o
    );

    modport slave (
        output active_i, domain_en_i, idle_i, step_mode_i, step_load_i,
               step_count_i, token_release_i,
        input  trigger_o, counter_o, steps_left_o, done_o, running_o,
               token_grant_o
    );
`endif
endinterface

// File: rtl/nx_cycle_ctrl.sv
// nx_cycle_ctrl: simulation-cycle controller for the accelerator top level.
// Issues a one-cycle trigger to every enabled mesh domain once all enabled
// domains are idle, counts issued triggers, grants the column token bus
// during the grant cycle after reset, and supports a bounded step mode that
// halts after a loaded number of triggers with a done pulse on the last one.
// A trigger is only issued after the mesh has visibly gone busy following
// the previous trigger (WAIT_BUSY -> WAIT_IDLE handshake).
// Optional macro NX_CYCLE_BREAK_EN adds a counter breakpoint: when enabled
// and the counter equals break_cycle_i in WAIT_IDLE, the controller halts
// and raises break_o until break_en_i is cleared.
module nx_cycle_ctrl #(
    parameter int DOMAINS       = 1,
    parameter int COLUMNS       = 3,
    parameter int COUNTER_WIDTH = 32,
    parameter int STEP_WIDTH    = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    nx_cycle_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        GRANT     = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_IDLE = 2'd2,
        HALT      = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [DOMAINS-1:0]       trigger_q;
    logic [DOMAINS-1:0]       trigger_next;
    logic [COUNTER_WIDTH-1:0] counter_q;
    logic [COUNTER_WIDTH-1:0] counter_next;
    logic [STEP_WIDTH-1:0]    steps_q;
    logic [STEP_WIDTH-1:0]    steps_next;
    logic                     done_q;
    logic                     done_next;

    logic                     all_idle;
    logic                     any_busy;
    logic                     fire;
    logic                     exhausted;
    logic                     take_fire;

    // Breakpoint hooks; tied off when the breakpoint feature is absent so
    // the FSM below is written once for both builds.
    logic                     break_hit;
    logic                     break_hold;
    logic                     break_release;

    // Disabled domains count as idle and never as busy, so an all-zero mask
    // parks the FSM in WAIT_BUSY.
    assign all_idle  = &(bus.idle_i | ~bus.domain_en_i);
    assign any_busy  = |(~bus.idle_i & bus.domain_en_i);
    assign fire      = bus.active_i && all_idle &&
                       (!bus.step_mode_i || (steps_q != '0));
    assign exhausted = bus.step_mode_i && (steps_q == '0);

`ifdef NX_CYCLE_BREAK_EN
    logic break_q;

    assign break_hit     = bus.break_en_i && (counter_q == bus.break_cycle_i);
    assign break_hold    = break_q;
    assign break_release = break_q && !bus.break_en_i;
    assign bus.break_o   = break_q;

    // Breakpoint halt flag: set on a breakpoint hit in WAIT_IDLE, held while
    // break_en_i stays high (the FSM is in HALT for exactly that span).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            break_q <= 1'b0;
        end else begin
            break_q <= ((state == WAIT_IDLE) && break_hit) ||
                       (break_q && bus.break_en_i);
        end
    end
`else
    assign break_hit     = 1'b0;
    assign break_hold    = 1'b0;
    assign break_release = 1'b0;
`endif

    // Next-state and next-datapath logic for the trigger handshake FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next   = state;
        trigger_next = '0;
        counter_next = counter_q;
        steps_next   = steps_q;
        done_next    = 1'b0;
        take_fire    = 1'b0;

        unique case (state)
            GRANT: begin
                state_next = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (any_busy) begin
                    state_next = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                // Breakpoint outranks both firing and step exhaustion.
                if (break_hit) begin
                    state_next = HALT;
                end else if (fire) begin
                    take_fire    = 1'b1;
                    trigger_next = bus.domain_en_i;
                    counter_next = counter_q + 1'b1;
                    state_next   = WAIT_BUSY;
                end else if (exhausted) begin
                    state_next = HALT;
                end
            end

            HALT: begin
                // A breakpoint halt is released only by clearing break_en_i;
                // busy was already observed, so resume in WAIT_IDLE.
                if (break_hold) begin
                    if (break_release) begin
                        state_next = WAIT_IDLE;
                    end
                end else if ((bus.step_load_i && (bus.step_count_i != '0)) ||
                             !bus.step_mode_i) begin
                    state_next = WAIT_IDLE;
                end
            end

            default: begin
                state_next = GRANT;
            end
        endcase

        // A load in any state overrides a same-cycle decrement and its done.
        if (bus.step_load_i) begin
            steps_next = bus.step_count_i;
        end else if (take_fire && bus.step_mode_i) begin
            steps_next = steps_q - 1'b1;
            done_next  = (steps_q == STEP_WIDTH'(1));
        end
    end

    // State register; reset re-enters the grant cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample pre-edge values regardless of process ordering.
        if (rst_i) begin
            state <= GRANT;
        end else begin
            state <= state_next;
        end
    end

    // Registered trigger pulse, cycle counter, step count and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trigger_q <= '0;
            counter_q <= '0;
            steps_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            trigger_q <= trigger_next;
            counter_q <= counter_next;
            steps_q   <= steps_next;
            done_q    <= done_next;
        end
    end

    assign bus.trigger_o     = trigger_q;
    assign bus.counter_o     = counter_q;
    assign bus.steps_left_o  = steps_q;
    assign bus.done_o        = done_q;
    assign bus.running_o     = (state != HALT);
    assign bus.token_grant_o = (state == GRANT) ? '1 : bus.token_release_i;

endmodule

// File: doc/nx_cycle_ctrl.md
Name: nx_cycle_ctrl

Overview:
Parametrised simulation-cycle controller for the accelerator top level. It generates the global trigger pulse and the cycle counter across DOMAINS independently-enabled mesh domains. It also drives the column token-grant bus. Beyond free-running triggering, it supports a bounded step mode: run N cycles, then halt with a done pulse.

Parameters:
DOMAINS, 1, number of mesh domains with separate idle inputs and trigger outputs
COLUMNS, 3, width of the token grant/release buses
COUNTER_WIDTH, 32, width of the simulated-cycle counter
STEP_WIDTH, 16, width of the step-count register

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; asynchronous, active-high
active_i  input  1  global run enable
domain_en_i  input  DOMAINS  per-domain participation mask
idle_i  input  DOMAINS  per-domain idle from mesh
trigger_o  output  DOMAINS  one-cycle trigger pulse, per domain, masked by domain_en_i
counter_o  output  COUNTER_WIDTH  count of triggers issued
step_mode_i  input  1  1 = bounded step mode, 0 = free-run
step_load_i  input  1  load step_count_i into the remaining-steps register
step_count_i  input  STEP_WIDTH  steps to run
steps_left_o  output  STEP_WIDTH  remaining steps
done_o  output  1  one-cycle pulse coincident with the final step's trigger
running_o  output  1  1 when state is not HALT
token_release_i  input  COLUMNS  token release from mesh
token_grant_o  output  COLUMNS  token grant to mesh

Behaviour:
- Reset values:
  - trigger_o=0, counter_o=0, steps_left_o=0, done_o=0.
  - State=GRANT, so running_o=1.
- token_grant_o:
  - All ones while state==GRANT.
  - Otherwise combinationally equal to token_release_i.
- Enabled-domain reduction terms:
  - all_idle = &(idle_i | ~domain_en_i).
  - any_busy = |(~idle_i & domain_en_i).
- Transition conditions:
  - fire = active_i & all_idle & (!step_mode_i | steps_left!=0).
  - Step exhaustion = step_mode_i & steps_left==0.
- FSM states, with transitions evaluated each rising edge:
  - GRANT: unconditionally goes to WAIT_BUSY after one cycle.
  - WAIT_BUSY: goes to WAIT_IDLE when any_busy=1. This guarantees a trigger is never issued until the mesh has visibly consumed the previous one.
  - WAIT_IDLE:
    - If fire: register trigger_o = domain_en_i for exactly one cycle and increment counter_o by 1 (wraps to 0 at max).
    - Also on fire, if step_mode_i, decrement steps_left; if it becomes 0, assert done_o in the same cycle as trigger_o. Then go to WAIT_BUSY.
    - Else if step exhaustion: go to HALT.
  - HALT: step_load_i with step_count_i!=0 returns to WAIT_IDLE (busy already seen). Deasserting step_mode_i also returns to WAIT_IDLE.
- Trigger latency: trigger_o rises in the cycle after the edge where fire is sampled true.
- step_load_i is accepted in any state.
  - If it coincides with a decrement, the load wins: steps_left=step_count_i and no done_o pulse.
  - step_count_i=0 loaded in HALT keeps HALT.
- domain_en_i changes take effect immediately on the reduction terms.
  - Mask all zero: any_busy=0, so the FSM parks in WAIT_BUSY with no triggers.
- active_i low: no new trigger; the FSM otherwise still tracks busy/idle.
- rst_i assertion mid-trigger:
  - Outputs clear asynchronously.
  - Grant cycle is repeated after release.

Optional Feature:
Macro NX_CYCLE_BREAK_EN.
- Defined:
  - Adds inputs break_en_i (1) and break_cycle_i (COUNTER_WIDTH), and output break_o (1).
  - In WAIT_IDLE, if break_en_i and counter_o==break_cycle_i, fire is suppressed and the FSM goes to HALT. break_o is held high while in HALT for this reason.
  - Clearing break_en_i leaves HALT for WAIT_IDLE and drops break_o.
  - The break check takes priority over the step check.
- Undefined: none of these ports exist; behaviour is exactly as above.

Test Plan:
- Grant after reset: release rst_i, token_release_i=3'b010 → token_grant_o=3'b111 for cycle 1, then 3'b010. trigger_o=0, counter_o=0.
- Free-run: DOMAINS=2, en=2'b11. Toggle idle low for 2 cycles then high, 4 times → 4 single-cycle trigger_o=2'b11 pulses, counter_o=4. No trigger before the first busy.
- Masking: en=2'b01, idle_i[1] held 0 → triggers still fire on idle_i[0] only, trigger_o=2'b01.
- Step mode: step_mode_i=1, load 3, mesh cycling → exactly 3 triggers. done_o coincides with the 3rd, steps_left_o=0, running_o=0. Load 2 → 2 more, counter_o=5.
- Load/decrement collision: step_load_i=1, step_count_i=7 on the final-step fire edge → steps_left_o=7, done_o=0, FSM continues.
- With NX_CYCLE_BREAK_EN: break_cycle_i=10, free-run → counter_o stops at 10, break_o=1. Clear break_en_i → triggers resume, counter_o reaches 11.
